// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and digit helpers for the sequential BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam int MAX_DIGITS = 16;
  function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
    return (d >= 4'd5 && d <= BCD_NINE) ? d + 4'd3 : d;
  endfunction
  function automatic int ndigits_of(input logic [4*MAX_DIGITS-1:0] bcd);
    int n;
    n = 1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (bcd[4*i +: 4] != 4'd0) n = i + 1;
    return n;
  endfunction
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: single-digit double-dabble correction (>=5 gets +3)
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = add3_if_ge5(d);
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: iterative binary-to-BCD converter, one adjust-and-shift step per clock
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS = 8,
  localparam int CNT_W = $clog2(BIN_WIDTH + 1),
  localparam int NDW = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic [NDW-1:0]        out_ndigits,
  output logic                  out_ovf
);
  localparam int SW = BIN_WIDTH + 4*DIGITS;
  state_t state, state_nx;
  logic [SW-1:0] sr, adj, step;
  logic [CNT_W-1:0] cnt;
  logic ovf_acc, ovf_step;
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (.d(sr[BIN_WIDTH+4*g +: 4]), .q(adj[BIN_WIDTH+4*g +: 4]));
  end
  assign adj[BIN_WIDTH-1:0] = sr[BIN_WIDTH-1:0];
  assign step = {adj[SW-2:0], 1'b0};
  assign ovf_step = ovf_acc | adj[SW-1];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next-state: accept in IDLE, count steps in CONV, wait for consumer in DONE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = in_valid ? CONV : IDLE;
      CONV: state_nx = cnt == CNT_W'(1) ? DONE : CONV;
      DONE: state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // datapath: load on accept, step while converting, capture results on the last step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sr <= '0;
      cnt <= '0;
      ovf_acc <= 1'b0;
      out_bcd <= '0;
      out_ndigits <= NDW'(1);
      out_ovf <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      sr <= {{(4*DIGITS){1'b0}}, in_bin};
      cnt <= CNT_W'(BIN_WIDTH);
      ovf_acc <= 1'b0;
    end else if (state == CONV) begin
      sr <= step;
      cnt <= cnt - 1'b1;
      ovf_acc <= ovf_step;
      if (cnt == CNT_W'(1)) begin
        out_bcd <= ovf_step ? {DIGITS{BCD_NINE}} : step[SW-1:BIN_WIDTH];
        out_ndigits <= ovf_step ? NDW'(DIGITS) : NDW'(ndigits_of((4*MAX_DIGITS)'(step[SW-1:BIN_WIDTH])));
        out_ovf <= ovf_step;
      end
    end
endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb_bcd_seq_converter: directed self-checking bench for the sequential BCD converter
module tb_bcd_seq_converter;
  logic clk, rst_n, in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [31:0] in_bin, out_bcd;
  logic [3:0] out_ndigits;
  int n_asserts = 0;
  int n_fail = 0;

  bcd_seq_converter dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_bcd(out_bcd),
    .out_ndigits(out_ndigits), .out_ovf(out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic accept(input logic [31:0] v);
    in_valid = 1'b1;
    in_bin = v;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
  endtask

  task automatic check_out(input string tag, input logic [31:0] bcd, input int nd, input logic ovf);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_bcd"}, 64'(out_bcd), 64'(bcd));
    chk({tag, "_nd"}, 64'(out_ndigits), 64'(nd));
    chk({tag, "_ovf"}, 64'(out_ovf), 64'(ovf));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("ready_back", 64'(in_ready), 64'd1);
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] bcd, input int nd, input logic ovf);
    accept(v);
    wait_valid(32);
    check_out(tag, bcd, nd, ovf);
    release_out();
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_bin = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_bcd", 64'(out_bcd), 64'd0);
    chk("rst_nd", 64'(out_ndigits), 64'd1);
    chk("rst_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    convert("zero", 32'd0, 32'h0000_0000, 1, 1'b0);
    convert("mid", 32'd12345678, 32'h1234_5678, 8, 1'b0);
    convert("max", 32'd99999999, 32'h9999_9999, 8, 1'b0);
    convert("ovf1", 32'd100000000, 32'h9999_9999, 8, 1'b1);
    convert("ovf2", 32'd4294967295, 32'h9999_9999, 8, 1'b1);
    accept(32'd305);
    wait_valid(32);
    check_out("bp", 32'h0000_0305, 3, 1'b0);
    in_valid = 1'b1;
    in_bin = 32'd999;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_bcd", 64'(out_bcd), 64'h305);
      chk("bp_hold_nd", 64'(out_ndigits), 64'd3);
      chk("bp_hold_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    release_out();
    chk("hold_after_idle", 64'(out_bcd), 64'h305);
    accept(32'd4321);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(in_ready), 64'd1);
    chk("mrst_bcd", 64'(out_bcd), 64'd0);
    chk("mrst_nd", 64'(out_ndigits), 64'd1);
    chk("mrst_ovf", 64'(out_ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    convert("seven", 32'd7, 32'h0000_0007, 1, 1'b0);
    accept(32'd9);
    in_valid = 1'b1;
    in_bin = 32'd10;
    wait_valid(32);
    check_out("b2b_9", 32'h0000_0009, 1, 1'b0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("b2b_drop", 64'(out_valid), 64'd0);
    chk("b2b_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_valid(32);
    check_out("b2b_10", 32'h0000_0010, 2, 1'b0);
    release_out();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
